cpu_control_unit: RTL and testbench

- Instruction sequencer for the 16-bit CPU; it is the issuing side of the ALU interface.
- Fetches a 16-bit instruction, reads two operands from the register file, and drives alu_code and operands to the ALU.
- Consumes accum and pc_branch from the ALU, then writes back the result or updates the PC.
- Multi-cycle design with no pipelining: one instruction every 4 cycles.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_control_unit.sv | 106 ++++++++++
 tb/tb_cpu_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and instruction field positions shared by the CPU blocks
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BLT  = 4'b1101;
    localparam logic [3:0] OP_BGT  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int FIELD_W = 4;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return op == OP_BEQ || op == OP_BLT || op == OP_BGT;
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: four-cycle fetch/decode/execute/writeback sequencer driving the ALU
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_code,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    input  logic [DATA_W-1:0] alu_accum,
    input  logic              alu_pc_branch,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              retire
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] accum_q, accum_d;
    logic              taken_q, taken_d;

    logic [3:0]        opcode, rd, rs1, rs2;
    logic [PC_W-1:0]   offset_ext;
    logic              exec, wb;

    assign opcode     = ir_q[OPC_LSB +: FIELD_W];
    assign rd         = ir_q[RD_LSB +: FIELD_W];
    assign rs1        = ir_q[RS1_LSB +: FIELD_W];
    assign rs2        = ir_q[RS2_LSB +: FIELD_W];
    assign offset_ext = {{(PC_W-FIELD_W){rd[3]}}, rd};
    assign exec       = state_q == S_EXECUTE;
    assign wb         = state_q == S_WRITEBACK;

    // Next-state and datapath register updates for each sequencer phase
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        accum_d = accum_q;
        taken_d = taken_q;
        case (state_q)
            S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_rdata;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                accum_d = alu_accum;
                taken_d = alu_pc_branch;
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + PC_W'(1) + ((is_branch(opcode) && taken_q) ? offset_ext : '0);
                state_d = opcode == OP_HALT ? S_HALT : run ? S_FETCH : S_IDLE;
            end
            default:     state_d = state_q;
        endcase
    end

    // State registers; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            accum_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            accum_q <= accum_d;
            taken_q <= taken_d;
        end
    end

    // Outputs are decoded from registered state so they are quiet outside their phase
    assign imem_addr = state_q == S_FETCH ? pc_q : '0;
    assign rf_raddr1 = exec ? rs1 : '0;
    assign rf_raddr2 = exec ? rs2 : '0;
    assign alu_code  = (exec && (is_arith(opcode) || is_branch(opcode))) ? opcode : OP_NOP;
    assign alu_data1 = exec ? rf_rdata1 : '0;
    assign alu_data2 = exec ? rf_rdata2 : '0;
    assign rf_we     = wb && is_arith(opcode);
    assign rf_waddr  = rf_we ? rd : '0;
    assign rf_wdata  = rf_we ? accum_q : '0;
    assign retire    = wb;
    assign halted    = state_q == S_HALT;
    assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: ISA-level scoreboard bench with instruction memory, register file and ALU models
module tb_cpu_control_unit;

    logic        clk, rst, run;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_rdata, rf_rdata1, rf_rdata2, rf_wdata, alu_data1, alu_data2, alu_accum;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_code;
    logic        rf_we, alu_pc_branch, halted, retire;

    logic [15:0] imem [256];
    logic [15:0] rf   [16];
    logic [15:0] m_rf [16];
    logic [7:0]  m_pc;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [7:0]  pc;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int ret_cnt = 0;

    cpu_control_unit #(.PC_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_code(alu_code), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_accum(alu_accum), .alu_pc_branch(alu_pc_branch),
        .pc(pc), .halted(halted), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memory and register file with combinational reads
    initial begin
        for (int i = 0; i < 16; i++) rf[i] <= 16'h0;
        forever begin
            @(posedge clk);
            imem_rdata <= imem[imem_addr];
            if (rf_we) rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    // Reference ALU
    always_comb begin
        alu_accum     = 16'h0;
        alu_pc_branch = 1'b0;
        case (alu_code)
            4'b1000: alu_accum = alu_data1 + alu_data2;
            4'b0100: alu_accum = alu_data1 - alu_data2;
            4'b1100: alu_pc_branch = alu_data1 == alu_data2;
            4'b1101: alu_pc_branch = $signed(alu_data1) < $signed(alu_data2);
            4'b1110: alu_pc_branch = $signed(alu_data1) > $signed(alu_data2);
            default: alu_accum = 16'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Retirement monitor: pops the scoreboard on retire, checks the PC one cycle later
    initial begin
        exp_t e;
        logic pc_pend;
        logic [7:0] pc_exp;
        pc_pend = 1'b0;
        pc_exp  = 8'h0;
        forever begin
            @(negedge clk);
            if (rf_we) we_cnt++;
            if (pc_pend) begin
                check("pc_after_retire", {24'h0, pc}, {24'h0, pc_exp});
                pc_pend = 1'b0;
            end
            if (retire) begin
                ret_cnt++;
                if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("rf_we", {31'h0, rf_we}, {31'h0, e.we});
                    check("rf_waddr", {28'h0, rf_waddr}, {28'h0, e.waddr});
                    check("rf_wdata", {16'h0, rf_wdata}, {16'h0, e.wdata});
                    pc_exp  = e.pc;
                    pc_pend = 1'b1;
                end
            end
        end
    end

    task automatic set_reg(input int i, input logic [15:0] v);
        rf[i]   <= v;
        m_rf[i]  = v;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    // Instruction-set model: predicts each retirement from program memory and model registers
    task automatic model_push(input int n);
        for (int k = 0; k < n; k++) begin
            logic [15:0] ins, a, b;
            logic [3:0]  op, rd;
            logic        tk;
            exp_t        e;
            ins = imem[m_pc];
            op  = ins[15:12];
            rd  = ins[11:8];
            a   = m_rf[ins[7:4]];
            b   = m_rf[ins[3:0]];
            e.we = 1'b0; e.waddr = 4'h0; e.wdata = 16'h0;
            if (op == 4'b1000 || op == 4'b0100) begin
                e.we    = 1'b1;
                e.waddr = rd;
                e.wdata = op == 4'b1000 ? a + b : a - b;
                m_rf[rd] = e.wdata;
            end
            tk = (op == 4'hC && a == b) || (op == 4'hD && $signed(a) < $signed(b))
              || (op == 4'hE && $signed(a) > $signed(b));
            m_pc = m_pc + 8'd1 + (tk ? {{4{rd[3]}}, rd} : 8'd0);
            e.pc = m_pc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_retires(input int n);
        int c = 0;
        int cyc = 0;
        while (c < n && cyc < 60 * n) begin
            @(negedge clk);
            cyc++;
            if (retire) c++;
        end
        run = 1'b0;
        if (c < n) check("retire_timeout", c, n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        m_pc = 8'h0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_imem_addr"}, {24'h0, imem_addr}, 32'h0);
        check({tag, "_raddr"}, {24'h0, rf_raddr1, rf_raddr2}, 32'h0);
        check({tag, "_rf_write"}, {11'h0, rf_we, rf_waddr, rf_wdata}, 32'h0);
        check({tag, "_alu_code"}, {28'h0, alu_code}, 32'h0);
        check({tag, "_alu_data"}, {alu_data1, alu_data2}, 32'h0);
        check({tag, "_pc"}, {24'h0, pc}, 32'h0);
        check({tag, "_flags"}, {30'h0, halted, retire}, 32'h0);
    endtask

    initial begin
        int w0, r0, bad;
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        clear_imem();

        // ADD r3 = r1 + r2 with cycle-accurate ALU issue check
        do_reset();
        check_quiet("reset");
        imem[0] = 16'h8312;
        set_reg(1, 16'd1);
        set_reg(2, 16'd63);
        model_push(1);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("add_alu_code", {28'h0, alu_code}, 32'h8);
        check("add_alu_ops", {alu_data1, alu_data2}, {16'd1, 16'd63});
        check("add_raddr", {24'h0, rf_raddr1, rf_raddr2}, 32'h12);
        wait_retires(1);
        check("add_r3", {16'h0, rf[3]}, 32'd64);

        // SUB r5 = r1 - r2, exactly one write pulse
        do_reset();
        imem[0] = 16'h4512;
        set_reg(1, 16'd63);
        set_reg(2, 16'd1);
        w0 = we_cnt;
        model_push(1);
        run = 1'b1;
        wait_retires(1);
        check("sub_we_pulses", we_cnt - w0, 1);
        check("sub_r5", {16'h0, rf[5]}, 32'd62);

        // BEQ taken and not taken, never writes
        do_reset();
        imem[0] = 16'hC212;
        set_reg(1, 16'd1);
        set_reg(2, 16'd1);
        w0 = we_cnt;
        model_push(1);
        run = 1'b1;
        wait_retires(1);
        check("beq_taken_pc", {24'h0, pc}, 32'd3);
        do_reset();
        set_reg(2, 16'd3);
        model_push(1);
        run = 1'b1;
        wait_retires(1);
        check("beq_not_taken_pc", {24'h0, pc}, 32'd1);
        check("beq_no_write", we_cnt - w0, 0);

        // BGT with offset -1 loops on itself
        do_reset();
        clear_imem();
        imem[5] = 16'hEF12;
        set_reg(1, 16'd5);
        set_reg(2, 16'hFFFF);
        model_push(8);
        run = 1'b1;
        wait_retires(8);
        check("bgt_loop_pc", {24'h0, pc}, 32'd5);

        // NOP run across the 255 -> 0 wrap
        do_reset();
        clear_imem();
        model_push(257);
        run = 1'b1;
        wait_retires(257);
        check("wrap_pc", {24'h0, pc}, 32'd1);

        // HALT at address 2, then hold until reset
        do_reset();
        imem[2] = 16'hF000;
        model_push(3);
        run = 1'b1;
        wait_retires(3);
        check("halted_set", {31'h0, halted}, 32'd1);
        run = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (retire || !halted || imem_addr != 8'h0 || pc != 8'd3) bad++;
        end
        check("halt_hold", bad, 0);
        do_reset();
        check("halt_cleared", {23'h0, halted, pc}, 32'h0);

        // Reset during EXECUTE of an ADD suppresses the write
        clear_imem();
        imem[0] = 16'h8312;
        w0 = we_cnt;
        r0 = ret_cnt;
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("exec_before_rst", {28'h0, alu_code}, 32'h8);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check_quiet("mid_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_write", we_cnt - w0, 0);
        check("mid_rst_no_retire", ret_cnt - r0, 0);
        check("mid_rst_idle", {24'h0, imem_addr}, 32'h0);

        // Drop run during DECODE: instruction completes, then idle, then resume
        do_reset();
        set_reg(1, 16'd7);
        set_reg(2, 16'd2);
        imem[1] = 16'h4612;
        model_push(1);
        run = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
        wait_retires(1);
        check("drop_run_pc", {24'h0, pc}, 32'd1);
        r0 = ret_cnt;
        repeat (6) @(negedge clk);
        check("drop_run_parked", ret_cnt - r0, 0);
        model_push(1);
        run = 1'b1;
        wait_retires(1);
        check("resume_r6", {16'h0, rf[6]}, 32'd5);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
